// File: rtl/game_event_bridge.sv
// -----------------------------------------------------------------------------
// game_event_bridge
//
// Bridges game-logic events into the processor register file.
//
//  * Points channel: line-clear events are queued in a 4-deep FIFO of 3-bit
//    point values. A small FSM presents the FIFO head on addPoints with the
//    register-29 write strobe (fromGame[0]). It pops once the register file
//    accepts the write, then waits for the processor to echo the sequence
//    number in proc_reg2[7:0] before it posts the next value.
//  * Rotate channel: rotate requests set a pending flag that drives the
//    register-27 write strobe (fromGame[1]) and rotate=1 until the write is
//    accepted. Requests that arrive while one is pending merge into it.
//  * Status mirrors: blockType latches piece_type on piece_spawn. score and
//    next_piece are one-cycle registered copies of processor registers.
//
// Ports
//   clock            in   1   system clock, rising edge
//   ctrl_reset       in   1   asynchronous active-high clear of all state
//   cpu_write_busy   in   1   regfile ignores game writes while high
//   line_clear_valid in   1   pulse: lines were cleared
//   lines_cleared    in   3   lines cleared (0 ignored, 5..7 clamp to 4)
//   rotate_req       in   1   pulse: player rotate request
//   piece_spawn      in   1   pulse: new piece spawned
//   piece_type       in   4   type of the spawned piece
//   proc_reg1        in  32   processor score register
//   proc_reg2        in  32   [7:0] consumed-points sequence number
//   proc_reg3        in  32   [3:0] next-piece preview
//   addPoints        out  3   points value for register 29
//   blockType        out  4   current piece type for register 28
//   rotate           out  1   rotate value for register 27
//   fromGame         out  2   write strobes: bit0 reg 29, bit1 reg 27
//   score            out 32   registered proc_reg1
//   next_piece       out  4   registered proc_reg3[3:0]
//   fifo_count       out  3   points FIFO occupancy, 0..4
//   overflow         out  1   sticky: a points event was dropped
// -----------------------------------------------------------------------------
module game_event_bridge (
    input  logic        clock,
    input  logic        ctrl_reset,
    input  logic        cpu_write_busy,
    input  logic        line_clear_valid,
    input  logic [2:0]  lines_cleared,
    input  logic        rotate_req,
    input  logic        piece_spawn,
    input  logic [3:0]  piece_type,
    input  logic [31:0] proc_reg1,
    input  logic [31:0] proc_reg2,
    input  logic [31:0] proc_reg3,
    output logic [2:0]  addPoints,
    output logic [3:0]  blockType,
    output logic        rotate,
    output logic [1:0]  fromGame,
    output logic [31:0] score,
    output logic [3:0]  next_piece,
    output logic [2:0]  fifo_count,
    output logic        overflow
);

    localparam int FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        P_IDLE = 2'd0,
        P_POST = 2'd1,
        P_WAIT = 2'd2
    } p_state_t;

    // Four lines is the largest real clear, so larger codes saturate there.
    function automatic logic [2:0] clamp_points(input logic [2:0] lines);
        if (lines > 3'd4) begin
            return 3'd4;
        end
        return lines;
    endfunction

    // Points FIFO state
    logic [2:0] fifo_mem_q [FIFO_DEPTH];
    logic [2:0] fifo_mem_d [FIFO_DEPTH];
    logic [1:0] wr_ptr_q, wr_ptr_d;
    logic [1:0] rd_ptr_q, rd_ptr_d;
    logic [2:0] fifo_count_q, fifo_count_d;
    logic       overflow_q, overflow_d;

    // Points handshake FSM state
    p_state_t   p_state_q, p_state_d;
    logic [7:0] post_seq_q, post_seq_d;

    // Rotate channel and status mirrors
    logic        rot_pending_q, rot_pending_d;
    logic [3:0]  block_type_q, block_type_d;
    logic [31:0] score_q, score_d;
    logic [3:0]  next_piece_q, next_piece_d;

    // Internal strobes
    logic       push_req;
    logic       push_ok;
    logic       push_drop;
    logic       pop;
    logic       fifo_full;
    logic [2:0] push_val;
    logic [2:0] fifo_head;

    // Only the low bytes/nibbles of these registers carry bridge data.
    logic unused_reg_bits;
    assign unused_reg_bits = ^{proc_reg2[31:8], proc_reg3[31:4]};

    assign fifo_head = fifo_mem_q[rd_ptr_q];
    assign fifo_full = (fifo_count_q == 3'(FIFO_DEPTH));
    assign push_req  = line_clear_valid && (lines_cleared != 3'd0);
    assign push_val  = clamp_points(lines_cleared);

    // A post is consumed on any P_POST cycle where the regfile is free.
    assign pop       = (p_state_q == P_POST) && !cpu_write_busy;

    // When full, a same-cycle pop frees the head slot. The write then lands
    // in that slot (wr_ptr == rd_ptr) after the head has been presented.
    assign push_ok   = push_req && (!fifo_full || pop);
    assign push_drop = push_req && fifo_full && !pop;

    // FIFO next-state
    always_comb begin
        fifo_mem_d = fifo_mem_q;
        if (push_ok) begin
            fifo_mem_d[wr_ptr_q] = push_val;
        end
        wr_ptr_d   = wr_ptr_q + {1'b0, push_ok};
        rd_ptr_d   = rd_ptr_q + {1'b0, pop};
        case ({push_ok, pop})
            2'b10:   fifo_count_d = fifo_count_q + 3'd1;
            2'b01:   fifo_count_d = fifo_count_q - 3'd1;
            default: fifo_count_d = fifo_count_q;
        endcase
        overflow_d = overflow_q | push_drop;
    end

    // Points FSM next-state
    always_comb begin
        p_state_d  = p_state_q;
        post_seq_d = post_seq_q;
        case (p_state_q)
            P_IDLE: begin
                if (fifo_count_q != 3'd0) begin
                    p_state_d = P_POST;
                end
            end
            P_POST: begin
                if (!cpu_write_busy) begin
                    p_state_d  = P_WAIT;
                    post_seq_d = post_seq_q + 8'd1;
                end
            end
            P_WAIT: begin
                // The processor echoes the sequence number once it has
                // consumed the points; there is deliberately no timeout.
                if (proc_reg2[7:0] == post_seq_q) begin
                    p_state_d = P_IDLE;
                end
            end
            default: p_state_d = P_IDLE;
        endcase
    end

    // Rotate channel and status mirrors next-state
    always_comb begin
        // A new request in the clearing cycle keeps the flag set.
        rot_pending_d = rotate_req | (rot_pending_q & cpu_write_busy);
        block_type_d  = piece_spawn ? piece_type : block_type_q;
        score_d       = proc_reg1;
        next_piece_d  = proc_reg3[3:0];
    end

    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_q[i] <= 3'd0;
            end
            wr_ptr_q      <= 2'd0;
            rd_ptr_q      <= 2'd0;
            fifo_count_q  <= 3'd0;
            overflow_q    <= 1'b0;
            p_state_q     <= P_IDLE;
            post_seq_q    <= 8'd0;
            rot_pending_q <= 1'b0;
            block_type_q  <= 4'd0;
            score_q       <= 32'd0;
            next_piece_q  <= 4'd0;
        end else begin
            fifo_mem_q    <= fifo_mem_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            fifo_count_q  <= fifo_count_d;
            overflow_q    <= overflow_d;
            p_state_q     <= p_state_d;
            post_seq_q    <= post_seq_d;
            rot_pending_q <= rot_pending_d;
            block_type_q  <= block_type_d;
            score_q       <= score_d;
            next_piece_q  <= next_piece_d;
        end
    end

    // Outputs decode straight from flops, so reset clears them at once.
    assign fromGame   = {rot_pending_q, (p_state_q == P_POST)};
    assign addPoints  = (p_state_q == P_POST) ? fifo_head : 3'd0;
    assign rotate     = rot_pending_q;
    assign blockType  = block_type_q;
    assign score      = score_q;
    assign next_piece = next_piece_q;
    assign fifo_count = fifo_count_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_game_event_bridge.sv
module tb_game_event_bridge;

    logic        clock;
    logic        ctrl_reset;
    logic        cpu_write_busy;
    logic        line_clear_valid;
    logic [2:0]  lines_cleared;
    logic        rotate_req;
    logic        piece_spawn;
    logic [3:0]  piece_type;
    logic [31:0] proc_reg1;
    logic [31:0] proc_reg2;
    logic [31:0] proc_reg3;
    logic [2:0]  addPoints;
    logic [3:0]  blockType;
    logic        rotate;
    logic [1:0]  fromGame;
    logic [31:0] score;
    logic [3:0]  next_piece;
    logic [2:0]  fifo_count;
    logic        overflow;

    int tests_run;
    int tests_failed;

    game_event_bridge dut (
        .clock            (clock),
        .ctrl_reset       (ctrl_reset),
        .cpu_write_busy   (cpu_write_busy),
        .line_clear_valid (line_clear_valid),
        .lines_cleared    (lines_cleared),
        .rotate_req       (rotate_req),
        .piece_spawn      (piece_spawn),
        .piece_type       (piece_type),
        .proc_reg1        (proc_reg1),
        .proc_reg2        (proc_reg2),
        .proc_reg3        (proc_reg3),
        .addPoints        (addPoints),
        .blockType        (blockType),
        .rotate           (rotate),
        .fromGame         (fromGame),
        .score            (score),
        .next_piece       (next_piece),
        .fifo_count       (fifo_count),
        .overflow         (overflow)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        #12;
        tests_run++;
        if ({fromGame, addPoints, rotate, blockType, fifo_count, overflow} !== 15'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got fromGame=%b addPoints=%0d rotate=%b blockType=%0d fifo_count=%0d overflow=%b, expected all 0",
                     fromGame, addPoints, rotate, blockType, fifo_count, overflow);
        end
        tests_run++;
        if (score !== 32'd0 || next_piece !== 4'd0) begin
            tests_failed++;
            $display("FAIL reset_regs: got score=%0d next_piece=%0d, expected 0 0", score, next_piece);
        end
        tick();
        ctrl_reset = 1'b0;
        tick();
        tests_run++;
        if (fromGame !== 2'b00 || fifo_count !== 3'd0) begin
            tests_failed++;
            $display("FAIL reset_release: got fromGame=%b fifo_count=%0d, expected 00 0", fromGame, fifo_count);
        end
    endtask

    // lines_cleared=3, regfile free: one-cycle post, then wait, then ack.
    task automatic test_basic_post();
        line_clear_valid = 1'b1;
        lines_cleared    = 3'd3;
        tick();
        line_clear_valid = 1'b0;
        lines_cleared    = 3'd0;
        tests_run++;
        if (fifo_count !== 3'd1 || fromGame !== 2'b00) begin
            tests_failed++;
            $display("FAIL basic_push: got fifo_count=%0d fromGame=%b, expected 1 00", fifo_count, fromGame);
        end
        tick();
        tests_run++;
        if (fromGame !== 2'b01 || addPoints !== 3'd3) begin
            tests_failed++;
            $display("FAIL basic_post: got fromGame=%b addPoints=%0d, expected 01 3", fromGame, addPoints);
        end
        tick();
        tests_run++;
        if (fromGame !== 2'b00 || addPoints !== 3'd0 || fifo_count !== 3'd0) begin
            tests_failed++;
            $display("FAIL basic_wait: got fromGame=%b addPoints=%0d fifo_count=%0d, expected 00 0 0",
                     fromGame, addPoints, fifo_count);
        end
        tick();
        tests_run++;
        if (fromGame !== 2'b00) begin
            tests_failed++;
            $display("FAIL basic_no_ack_hold: got fromGame=%b, expected 00", fromGame);
        end
        proc_reg2 = 32'd1;
        tick();
        tests_run++;
        if (fromGame !== 2'b00 || fifo_count !== 3'd0) begin
            tests_failed++;
            $display("FAIL basic_idle: got fromGame=%b fifo_count=%0d, expected 00 0", fromGame, fifo_count);
        end
    endtask

    // Regfile busy for 5 cycles while posting 2: strobe and value held.
    task automatic test_busy_hold();
        cpu_write_busy   = 1'b1;
        line_clear_valid = 1'b1;
        lines_cleared    = 3'd2;
        tick();
        line_clear_valid = 1'b0;
        lines_cleared    = 3'd0;
        tick();
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if (fromGame[0] !== 1'b1 || addPoints !== 3'd2 || fifo_count !== 3'd1) begin
                tests_failed++;
                $display("FAIL busy_hold[%0d]: got fromGame0=%b addPoints=%0d fifo_count=%0d, expected 1 2 1",
                         i, fromGame[0], addPoints, fifo_count);
            end
            tick();
        end
        cpu_write_busy = 1'b0;
        tests_run++;
        if (fromGame[0] !== 1'b1 || addPoints !== 3'd2) begin
            tests_failed++;
            $display("FAIL busy_last: got fromGame0=%b addPoints=%0d, expected 1 2", fromGame[0], addPoints);
        end
        tick();
        tests_run++;
        if (fromGame[0] !== 1'b0 || fifo_count !== 3'd0) begin
            tests_failed++;
            $display("FAIL busy_pop: got fromGame0=%b fifo_count=%0d, expected 0 0", fromGame[0], fifo_count);
        end
        proc_reg2 = 32'd2;
        tick();
    endtask

    // Six pushes with no ack after the first post: FIFO fills, last dropped.
    task automatic test_overflow();
        logic [2:0] vals [6];
        logic [2:0] cnt_exp [6];
        logic       ov_exp [6];
        vals    = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd2, 3'd1};
        cnt_exp = '{3'd1, 3'd2, 3'd2, 3'd3, 3'd4, 3'd4};
        ov_exp  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 6; i++) begin
            line_clear_valid = 1'b1;
            lines_cleared    = vals[i];
            tick();
            tests_run++;
            if (fifo_count !== cnt_exp[i] || overflow !== ov_exp[i]) begin
                tests_failed++;
                $display("FAIL ovf_fill[%0d]: got fifo_count=%0d overflow=%b, expected %0d %b",
                         i, fifo_count, overflow, cnt_exp[i], ov_exp[i]);
            end
            if (i == 1) begin
                tests_run++;
                if (fromGame[0] !== 1'b1 || addPoints !== 3'd1) begin
                    tests_failed++;
                    $display("FAIL ovf_first_post: got fromGame0=%b addPoints=%0d, expected 1 1",
                             fromGame[0], addPoints);
                end
            end
        end
        line_clear_valid = 1'b0;
        lines_cleared    = 3'd0;
    endtask

    // Full FIFO: push and pop in one cycle, then drain in order.
    task automatic test_full_push_pop();
        logic [2:0] drain_exp [4];
        logic [7:0] seq;
        drain_exp = '{3'd3, 3'd4, 3'd2, 3'd3};
        proc_reg2 = 32'd3;
        tick();
        tick();
        tests_run++;
        if (fromGame[0] !== 1'b1 || addPoints !== 3'd2 || fifo_count !== 3'd4) begin
            tests_failed++;
            $display("FAIL full_post: got fromGame0=%b addPoints=%0d fifo_count=%0d, expected 1 2 4",
                     fromGame[0], addPoints, fifo_count);
        end
        line_clear_valid = 1'b1;
        lines_cleared    = 3'd3;
        tick();
        line_clear_valid = 1'b0;
        lines_cleared    = 3'd0;
        tests_run++;
        if (fifo_count !== 3'd4 || overflow !== 1'b1 || fromGame[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL full_push_pop: got fifo_count=%0d overflow=%b fromGame0=%b, expected 4 1 0",
                     fifo_count, overflow, fromGame[0]);
        end
        seq = 8'd4;
        for (int i = 0; i < 4; i++) begin
            proc_reg2 = {24'd0, seq};
            tick();
            tick();
            tests_run++;
            if (fromGame[0] !== 1'b1 || addPoints !== drain_exp[i]) begin
                tests_failed++;
                $display("FAIL drain[%0d]: got fromGame0=%b addPoints=%0d, expected 1 %0d",
                         i, fromGame[0], addPoints, drain_exp[i]);
            end
            tick();
            seq = seq + 8'd1;
        end
        proc_reg2 = {24'd0, seq};
        tick();
        tests_run++;
        if (fifo_count !== 3'd0 || overflow !== 1'b1) begin
            tests_failed++;
            $display("FAIL drain_done: got fifo_count=%0d overflow=%b, expected 0 1", fifo_count, overflow);
        end
    endtask

    // lines_cleared=0 is ignored; 7 is clamped to 4.
    task automatic test_clamp();
        line_clear_valid = 1'b1;
        lines_cleared    = 3'd0;
        tick();
        line_clear_valid = 1'b0;
        tests_run++;
        if (fifo_count !== 3'd0) begin
            tests_failed++;
            $display("FAIL zero_lines_count: got fifo_count=%0d, expected 0", fifo_count);
        end
        tick();
        tests_run++;
        if (fromGame[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL zero_lines_post: got fromGame0=%b, expected 0", fromGame[0]);
        end
        line_clear_valid = 1'b1;
        lines_cleared    = 3'd7;
        tick();
        line_clear_valid = 1'b0;
        lines_cleared    = 3'd0;
        tick();
        tests_run++;
        if (fromGame[0] !== 1'b1 || addPoints !== 3'd4) begin
            tests_failed++;
            $display("FAIL clamp_7: got fromGame0=%b addPoints=%0d, expected 1 4", fromGame[0], addPoints);
        end
        tick();
        proc_reg2 = 32'd9;
        tick();
    endtask

    // Rotate requests merge while busy; set wins over clear; both strobes together.
    task automatic test_rotate();
        cpu_write_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rotate_req = 1'b1;
            tick();
            rotate_req = 1'b0;
            tick();
            tests_run++;
            if (fromGame[1] !== 1'b1 || rotate !== 1'b1) begin
                tests_failed++;
                $display("FAIL rot_pending[%0d]: got fromGame1=%b rotate=%b, expected 1 1", i, fromGame[1], rotate);
            end
        end
        cpu_write_busy = 1'b0;
        tick();
        tests_run++;
        if (fromGame !== 2'b00 || rotate !== 1'b0) begin
            tests_failed++;
            $display("FAIL rot_clear: got fromGame=%b rotate=%b, expected 00 0", fromGame, rotate);
        end
        tick();
        tests_run++;
        if (fromGame[1] !== 1'b0) begin
            tests_failed++;
            $display("FAIL rot_single_window: got fromGame1=%b, expected 0", fromGame[1]);
        end
        rotate_req = 1'b1;
        tick();
        tick();
        rotate_req = 1'b0;
        tests_run++;
        if (fromGame[1] !== 1'b1 || rotate !== 1'b1) begin
            tests_failed++;
            $display("FAIL rot_set_wins: got fromGame1=%b rotate=%b, expected 1 1", fromGame[1], rotate);
        end
        tick();
        tests_run++;
        if (fromGame[1] !== 1'b0) begin
            tests_failed++;
            $display("FAIL rot_set_wins_clear: got fromGame1=%b, expected 0", fromGame[1]);
        end
        cpu_write_busy   = 1'b1;
        rotate_req       = 1'b1;
        line_clear_valid = 1'b1;
        lines_cleared    = 3'd2;
        tick();
        rotate_req       = 1'b0;
        line_clear_valid = 1'b0;
        lines_cleared    = 3'd0;
        tick();
        tests_run++;
        if (fromGame !== 2'b11 || addPoints !== 3'd2 || rotate !== 1'b1) begin
            tests_failed++;
            $display("FAIL both_strobes: got fromGame=%b addPoints=%0d rotate=%b, expected 11 2 1",
                     fromGame, addPoints, rotate);
        end
        cpu_write_busy = 1'b0;
        tick();
        tests_run++;
        if (fromGame !== 2'b00 || fifo_count !== 3'd0) begin
            tests_failed++;
            $display("FAIL both_accept: got fromGame=%b fifo_count=%0d, expected 00 0", fromGame, fifo_count);
        end
        proc_reg2 = 32'd10;
        tick();
    endtask

    task automatic test_regs();
        piece_spawn = 1'b1;
        piece_type  = 4'd5;
        proc_reg1   = 32'd1200;
        proc_reg3   = 32'h6;
        #1;
        tests_run++;
        if (blockType !== 4'd0 || score !== 32'd0) begin
            tests_failed++;
            $display("FAIL regs_latency: got blockType=%0d score=%0d, expected 0 0", blockType, score);
        end
        tick();
        piece_spawn = 1'b0;
        piece_type  = 4'd9;
        proc_reg1   = 32'd77;
        tests_run++;
        if (blockType !== 4'd5 || score !== 32'd1200 || next_piece !== 4'd6) begin
            tests_failed++;
            $display("FAIL regs_load: got blockType=%0d score=%0d next_piece=%0d, expected 5 1200 6",
                     blockType, score, next_piece);
        end
        tick();
        tests_run++;
        if (blockType !== 4'd5 || score !== 32'd77) begin
            tests_failed++;
            $display("FAIL regs_hold: got blockType=%0d score=%0d, expected 5 77", blockType, score);
        end
    endtask

    // Reset while waiting for the ack with another event queued.
    task automatic test_reset_mid();
        line_clear_valid = 1'b1;
        lines_cleared    = 3'd3;
        tick();
        lines_cleared    = 3'd1;
        tick();
        line_clear_valid = 1'b0;
        lines_cleared    = 3'd0;
        rotate_req       = 1'b1;
        tick();
        rotate_req       = 1'b0;
        tests_run++;
        if (fifo_count !== 3'd1 || fromGame !== 2'b10) begin
            tests_failed++;
            $display("FAIL mid_setup: got fifo_count=%0d fromGame=%b, expected 1 10", fifo_count, fromGame);
        end
        #2;
        ctrl_reset = 1'b1;
        #1;
        tests_run++;
        if ({fromGame, addPoints, rotate, blockType, fifo_count, overflow} !== 15'd0 ||
            score !== 32'd0 || next_piece !== 4'd0) begin
            tests_failed++;
            $display("FAIL mid_reset: got fromGame=%b addPoints=%0d rotate=%b blockType=%0d fifo_count=%0d overflow=%b score=%0d next_piece=%0d, expected all 0",
                     fromGame, addPoints, rotate, blockType, fifo_count, overflow, score, next_piece);
        end
        proc_reg1 = 32'd0;
        proc_reg2 = 32'd0;
        proc_reg3 = 32'd0;
        #1;
        ctrl_reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            tests_run++;
            if (fromGame !== 2'b00 || fifo_count !== 3'd0) begin
                tests_failed++;
                $display("FAIL post_reset_quiet[%0d]: got fromGame=%b fifo_count=%0d, expected 00 0",
                         i, fromGame, fifo_count);
            end
        end
    endtask

    initial begin
        tests_run        = 0;
        tests_failed     = 0;
        ctrl_reset       = 1'b1;
        cpu_write_busy   = 1'b0;
        line_clear_valid = 1'b0;
        lines_cleared    = 3'd0;
        rotate_req       = 1'b0;
        piece_spawn      = 1'b0;
        piece_type       = 4'd0;
        proc_reg1        = 32'd0;
        proc_reg2        = 32'd0;
        proc_reg3        = 32'd0;

        test_reset();
        test_basic_post();
        test_busy_hold();
        test_overflow();
        test_full_push_pop();
        test_clamp();
        test_rotate();
        test_regs();
        test_reset_mid();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
